// File: rtl/gfx_cmd_pkg.sv
// Shared opcode constants, packet lengths and state encodings for the
// graphics command path.
package gfx_cmd_pkg;

  localparam logic [7:0] OPC_POINT = 8'd80;
  localparam logic [7:0] OPC_LINE  = 8'd76;

  // Packet lengths include the opcode byte itself.
  localparam logic [3:0] LEN_POINT = 4'd4;
  localparam logic [3:0] LEN_LINE  = 4'd8;

  typedef enum logic {
    P_HEAD,
    P_BODY
  } parser_state_e;

  typedef enum logic {
    O_IDLE,
    O_SEND
  } out_state_e;

  // Total packet length for an opcode; 0 marks a byte that is not an opcode.
  function automatic logic [3:0] pkt_len(input logic [7:0] op);
    logic [3:0] len;
    case (op)
      OPC_POINT: len = LEN_POINT;
      OPC_LINE:  len = LEN_LINE;
      default:   len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A push while full is taken
// only when a pop happens in the same cycle, which frees the slot.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cmd_framer.sv
// Frames a raw host byte stream into Point/Line packets, drops unknown
// opcodes, and forwards only complete packets so the CCU sees each packet
// as an uninterrupted burst.
module cmd_framer
  import gfx_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_cmd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            busy,
  output logic [ERRW-1:0] err_cnt
);

  localparam int PCW = $clog2(DEPTH / 4) + 1;

  if ((DEPTH < 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cmd_framer: DEPTH must be a power of two and at least 8");
  end

  parser_state_e  parser_q, parser_d;
  out_state_e     ostate_q, ostate_d;
  logic [2:0]     remain_q, remain_d;
  logic [3:0]     orem_q, orem_d;
  logic [3:0]     orem_eff;
  logic [PCW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [ERRW-1:0] err_q, err_d;

  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [3:0] in_len;
  logic       would_write;
  logic       accept;
  logic       push;
  logic       pop;
  logic       pkt_inc;
  logic       pkt_dec;

  sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Garbage in P_HEAD is never stored, so it is consumed even when full.
  // A stored byte may still enter a full FIFO when a pop frees a slot.
  assign in_len      = pkt_len(in_data);
  assign would_write = (parser_q == P_BODY) || (in_len != 4'd0);
  assign pop         = (ostate_q == O_SEND) && out_ready;
  assign in_ready    = ~(fifo_full & ~pop & would_write);
  assign accept      = in_valid & in_ready;
  assign push        = accept & would_write;
  assign busy        = ~fifo_empty | (parser_q == P_BODY);
  assign err_cnt     = err_q;

  // Input parser: recognise opcodes, count body bytes, flag packet completion.
  always_comb begin
    parser_d = parser_q;
    remain_d = remain_q;
    err_d    = err_q;
    pkt_inc  = 1'b0;
    if (accept) begin
      case (parser_q)
        P_HEAD: begin
          if (in_len != 4'd0) begin
            parser_d = P_BODY;
            remain_d = 3'(in_len - 4'd1);
          end else if (err_q != '1) begin
            err_d = err_q + ERRW'(1);
          end
        end
        P_BODY: begin
          remain_d = remain_q - 3'd1;
          if (remain_q == 3'd1) begin
            pkt_inc  = 1'b1;
            parser_d = P_HEAD;
          end
        end
        default: parser_d = P_HEAD;
      endcase
    end
  end

  // Output FSM: stream whole packets; orem of 0 in O_SEND means the head is
  // a fresh opcode whose length is read directly off the FIFO head.
  always_comb begin
    ostate_d  = ostate_q;
    orem_d    = orem_q;
    pkt_dec   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_cmd   = 8'd0;
    orem_eff  = (orem_q == 4'd0) ? pkt_len(fifo_head) : orem_q;
    case (ostate_q)
      O_IDLE: begin
        if (pkt_cnt_q != '0) begin
          ostate_d = O_SEND;
          orem_d   = pkt_len(fifo_head);
        end
      end
      O_SEND: begin
        out_valid = 1'b1;
        out_cmd   = fifo_head;
        out_last  = (orem_eff == 4'd1);
        if (out_ready) begin
          if (orem_eff == 4'd1) begin
            pkt_dec = 1'b1;
            orem_d  = 4'd0;
          end else begin
            orem_d  = orem_eff - 4'd1;
          end
        end
      end
      default: ostate_d = O_IDLE;
    endcase
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_inc && !pkt_dec)      pkt_cnt_d = pkt_cnt_q + PCW'(1);
    else if (!pkt_inc && pkt_dec) pkt_cnt_d = pkt_cnt_q - PCW'(1);
    if (pkt_dec && (pkt_cnt_d == '0)) ostate_d = O_IDLE;
  end

  // State registers; reset discards any partial or buffered packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parser_q  <= P_HEAD;
      ostate_q  <= O_IDLE;
      remain_q  <= '0;
      orem_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      parser_q  <= parser_d;
      ostate_q  <= ostate_d;
      remain_q  <= remain_d;
      orem_q    <= orem_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule
